// File: rtl/sd_decimator.sv
// Sinc^3 decimator: 1-bit sigma-delta stream (+1/-1) in, saturated signed PCM
// out at 1/OSR of the enabled rate, through a valid/ready register with a sticky overrun flag.
module sd_decimator #(
    parameter  int OSR = 16,
    localparam int L   = $clog2(OSR),
    localparam int OW  = 3*L + 1
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 en,
    input  logic                 in,
    input  logic                 clrOverrun,
    output logic signed [OW-1:0] outData,
    output logic                 outValid,
    input  logic                 outReady,
    output logic                 overrun
);
    localparam int W = 3*L + 2;
    localparam logic [W-1:0]  FULL    = W'(1) << (3*L);
    localparam logic [OW-1:0] POS_MAX = {1'b0, {(OW-1){1'b1}}};

    // Integrators and comb delays wrap mod 2^W; the comb differences stay exact.
    logic [2:0][W-1:0] integ;
    logic [2:0][W-1:0] dly;
    logic [L-1:0]      cnt;
    logic              dec;
    logic [W-1:0]      stp;
    logic [W-1:0]      c1, c2, c3;
    logic [OW-1:0]     sat;

    // 1 -> +1, 0 -> -1 (all ones)
    assign stp = {{(W-1){~in}}, 1'b1};

    always_comb begin
        c1  = integ[2] - dly[0];
        c2  = c1 - dly[1];
        c3  = c2 - dly[2];
        // only +OSR^3 falls outside the output range
        sat = (c3 == FULL) ? POS_MAX : c3[OW-1:0];
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            integ    <= '0;
            dly      <= '0;
            cnt      <= '0;
            dec      <= 1'b0;
            outData  <= '0;
            outValid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            dec <= en && (&cnt);
            if (en) begin
                cnt      <= cnt + L'(1);
                integ[0] <= integ[0] + stp;
                integ[1] <= integ[1] + integ[0];
                integ[2] <= integ[2] + integ[1];
            end
            // dec still completes when en has dropped after the window's last bit
            if (dec) begin
                dly[0]   <= integ[2];
                dly[1]   <= c1;
                dly[2]   <= c2;
                outData  <= sat;
                outValid <= 1'b1;
            end else if (outValid && outReady) begin
                outValid <= 1'b0;
            end
            if (dec && outValid && !outReady)
                overrun <= 1'b1;
            else if (clrOverrun)
                overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sd_decimator.sv
// Directed bench for sd_decimator at OSR=16 with hand-computed sinc^3 step responses.
module tb_sd_decimator;
    localparam int OSR = 16;
    localparam int OW  = 13;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic en = 1'b0;
    logic in = 1'b0;
    logic clrOverrun = 1'b0;
    logic outReady = 1'b0;
    logic signed [OW-1:0] outData;
    logic outValid;
    logic overrun;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int samp[64];
    int samp_t[64];
    int nsamp;
    int v1, v2;
    logic alt;

    sd_decimator #(.OSR(OSR)) dut (
        .clk(clk), .rstN(rstN), .en(en), .in(in), .clrOverrun(clrOverrun),
        .outData(outData), .outValid(outValid), .outReady(outReady), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        nchk++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic e, input logic b);
        en = e;
        in = b;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        en = 1'b0; in = 1'b0; clrOverrun = 1'b0; outReady = 1'b0;
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstN = 1'b1;
        cyc = 0;
    endtask

    // pat 0: all zeros, 1: all ones, 2: alternating from 1, 3: 2nd-order modulator at +0.5 FS
    task automatic gen_bit(input int pat, output logic b);
        int y, nv1;
        case (pat)
            0: b = 1'b0;
            1: b = 1'b1;
            2: begin b = alt; alt = ~alt; end
            default: begin
                b   = (v2 >= 0);
                y   = b ? 256 : -256;
                nv1 = v1 + (128 - y) / 2;
                v2  = v2 + (v1 - y) / 2;
                v1  = nv1;
            end
        endcase
    endtask

    task automatic collect(input int n, input int per, input int pat);
        logic e, b;
        nsamp = 0; alt = 1'b1; v1 = 0; v2 = 0; outReady = 1'b1;
        for (int k = 0; k < n*per*OSR + 4*OSR && nsamp < n; k++) begin
            e = (k % per == 0);
            b = in;
            if (e) gen_bit(pat, b);
            step(e, b);
            if (outValid) begin
                samp[nsamp]   = outData;
                samp_t[nsamp] = cyc;
                nsamp++;
            end
        end
        chk("collect_count", nsamp, n);
    endtask

    initial begin
        int sum, dev, first;

        do_reset();
        chk("rst_data", outData, 0);
        chk("rst_valid", outValid, 0);
        chk("rst_overrun", overrun, 0);

        // full-scale positive: step response 560, 3280, then 4096 clipped to 4095
        do_reset();
        collect(6, 1, 1);
        chk("pos_first_lat", samp_t[0], 17);
        chk("pos_s0", samp[0], 560);
        chk("pos_s1", samp[1], 3280);
        for (int k = 2; k < 6; k++) chk($sformatf("pos_s%0d", k), samp[k], 4095);
        chk("pos_spacing", samp_t[3] - samp_t[2], 16);
        chk("pos_overrun", overrun, 0);

        // full-scale negative: -4096 fits without clipping
        do_reset();
        collect(5, 1, 0);
        chk("neg_s0", samp[0], -560);
        chk("neg_s1", samp[1], -3280);
        for (int k = 2; k < 5; k++) chk($sformatf("neg_s%0d", k), samp[k], -4096);

        // alternating idle pattern
        do_reset();
        collect(6, 1, 2);
        for (int k = 2; k < 6; k++) chk($sformatf("idle_s%0d", k), samp[k], 0);

        // modulator at 64/128: mean within 2% of 2048
        do_reset();
        collect(34, 1, 3);
        sum = 0;
        for (int k = 2; k < 34; k++) sum += samp[k];
        dev = sum - 2048*32;
        if (dev < 0) dev = -dev;
        chk($sformatf("mod_mean_ok(sum=%0d)", sum), (dev*50 <= 2048*32) ? 1 : 0, 1);

        // enable 1-in-4: same values, 64-clock spacing
        do_reset();
        collect(4, 4, 1);
        chk("gate_first_lat", samp_t[0], 62);
        chk("gate_spacing01", samp_t[1] - samp_t[0], 64);
        chk("gate_spacing23", samp_t[3] - samp_t[2], 64);
        chk("gate_s0", samp[0], 560);
        chk("gate_s1", samp[1], 3280);
        chk("gate_s2", samp[2], 4095);
        chk("gate_s3", samp[3], 4095);

        // backpressure
        do_reset();
        outReady = 1'b0;
        repeat (16) step(1'b1, 1'b1);
        chk("bp_valid_before", outValid, 0);
        step(1'b1, 1'b1);
        chk("bp_valid1", outValid, 1);
        chk("bp_data1", outData, 560);
        chk("bp_ovr1", overrun, 0);
        repeat (16) step(1'b1, 1'b1);
        chk("bp_valid2", outValid, 1);
        chk("bp_data2", outData, 3280);
        chk("bp_ovr2", overrun, 1);
        clrOverrun = 1'b1;
        step(1'b1, 1'b1);
        clrOverrun = 1'b0;
        chk("bp_clr", overrun, 0);
        chk("bp_hold", outData, 3280);
        repeat (14) step(1'b1, 1'b1);
        outReady = 1'b1;
        step(1'b1, 1'b1);
        chk("bp_same_edge_valid", outValid, 1);
        chk("bp_same_edge_data", outData, 4095);
        chk("bp_same_edge_ovr", overrun, 0);
        outReady = 1'b0;
        repeat (15) step(1'b1, 1'b1);
        clrOverrun = 1'b1;
        step(1'b1, 1'b1);
        clrOverrun = 1'b0;
        chk("bp_set_wins", overrun, 1);
        outReady = 1'b1;
        step(1'b1, 1'b1);
        chk("bp_consume", outValid, 0);

        // asynchronous reset at cnt=7 with a pending sample and overrun set
        do_reset();
        outReady = 1'b0;
        repeat (39) step(1'b1, 1'b1);
        chk("mid_pre_ovr", overrun, 1);
        #3 rstN = 1'b0;
        #1;
        chk("mid_rst_data", outData, 0);
        chk("mid_rst_valid", outValid, 0);
        chk("mid_rst_ovr", overrun, 0);
        #2 rstN = 1'b1;
        cyc = 0;
        outReady = 1'b1;
        first = -1;
        for (int k = 0; k < 40 && first < 0; k++) begin
            step(1'b1, 1'b1);
            if (outValid) first = cyc;
        end
        chk("mid_first_lat", first, 17);
        chk("mid_first_data", outData, 560);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
